vga_timing_controller: RTL and testbench

Sequences the VGA raster for the Pong display. It consumes the divided `PixelClock` level from the pixel-clock divider and runs horizontal and vertical counters. From those it drives `HSync`, `VSync`, the visible-area flag and pixel coordinates. It also raises a once-per-frame update request toward the game logic so ball and paddle state change only during vertical blanking.

---
 rtl/vga_timing_controller.sv | 129 ++++++++++++
 tb/tb_vga_timing_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer for the Pong display.
// Detects rising edges of the divided pixel clock, steps the horizontal and
// vertical counters on each such tick, drives registered sync/visible flags
// aligned with the coordinates, and raises a once-per-frame update request
// at the start of vertical blanking.
module vga_timing_controller #(
    parameter int HVisible  = 640,
    parameter int HFront    = 16,
    parameter int HSyncW    = 96,
    parameter int HBack     = 48,
    parameter int VVisible  = 480,
    parameter int VFront    = 10,
    parameter int VSyncW    = 2,
    parameter int VBack     = 33,
    parameter int CountSize = 10
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 PixelClock,
    output logic                 HSync,
    output logic                 VSync,
    output logic                 Visible,
    output logic [CountSize-1:0] PixelX,
    output logic [CountSize-1:0] PixelY,
    output logic                 FrameStart,
    output logic                 UpdateReq,
    input  logic                 UpdateAck,
    output logic                 Overrun
);

    localparam int HTotal = HVisible + HFront + HSyncW + HBack;
    localparam int VTotal = VVisible + VFront + VSyncW + VBack;

    localparam logic [CountSize-1:0] X_LAST      = CountSize'(HTotal - 1);
    localparam logic [CountSize-1:0] Y_LAST      = CountSize'(VTotal - 1);
    localparam logic [CountSize-1:0] X_VIS_END   = CountSize'(HVisible);
    localparam logic [CountSize-1:0] Y_VIS_END   = CountSize'(VVisible);
    localparam logic [CountSize-1:0] HS_START    = CountSize'(HVisible + HFront);
    localparam logic [CountSize-1:0] HS_END      = CountSize'(HVisible + HFront + HSyncW);
    localparam logic [CountSize-1:0] VS_START    = CountSize'(VVisible + VFront);
    localparam logic [CountSize-1:0] VS_END      = CountSize'(VVisible + VFront + VSyncW);
    localparam logic [CountSize-1:0] COUNT_ONE   = CountSize'(1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    logic                 pc_prev_reg;
    state_t               state_reg;
    logic                 tick;
    logic                 x_wrap;
    logic [CountSize-1:0] x_next;
    logic [CountSize-1:0] y_next;
    logic                 frame_wrap;
    logic                 vblank_event;

    // Next-position arithmetic and the one-cycle events derived from it.
    always_comb begin
        tick         = PixelClock & ~pc_prev_reg;
        x_wrap       = (PixelX == X_LAST);
        x_next       = x_wrap ? '0 : (PixelX + COUNT_ONE);
        y_next       = PixelY;
        if (x_wrap) begin
            y_next = (PixelY == Y_LAST) ? '0 : (PixelY + COUNT_ONE);
        end
        frame_wrap   = tick && (x_next == '0) && (y_next == '0);
        vblank_event = tick && (x_next == '0) && (y_next == Y_VIS_END);
    end

    // Raster counters and flags; flags use the next position so they line
    // up with the coordinates presented in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_prev_reg <= 1'b0;
            PixelX      <= X_LAST;
            PixelY      <= Y_LAST;
            HSync       <= 1'b1;
            VSync       <= 1'b1;
            Visible     <= 1'b0;
            FrameStart  <= 1'b0;
        end else begin
            pc_prev_reg <= PixelClock;
            FrameStart  <= frame_wrap;
            if (tick) begin
                PixelX  <= x_next;
                PixelY  <= y_next;
                HSync   <= ~((x_next >= HS_START) && (x_next < HS_END));
                VSync   <= ~((y_next >= VS_START) && (y_next < VS_END));
                Visible <= (x_next < X_VIS_END) && (y_next < Y_VIS_END);
            end
        end
    end

    // Update-request handshake; a new blanking event while still pending
    // flags an overrun unless the ack lands in that very cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            UpdateReq <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (vblank_event) begin
                        state_reg <= PENDING;
                        UpdateReq <= 1'b1;
                    end
                end
                PENDING: begin
                    if (vblank_event) begin
                        UpdateReq <= 1'b1;
                        if (!UpdateAck) begin
                            Overrun <= 1'b1;
                        end
                    end else if (UpdateAck) begin
                        state_reg <= IDLE;
                        UpdateReq <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    UpdateReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench for vga_timing_controller using a shrunken raster so
// several whole frames fit in a short run. The reference model tracks a
// linear raster index per frame and derives coordinates and flags from it.
module tb_vga_timing_controller;

    localparam int HV  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 2;
    localparam int VV  = 6;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 2;
    localparam int CS  = 10;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [CS-1:0] x;
        logic [CS-1:0] y;
        logic          hs;
        logic          vs;
        logic          vis;
        logic          fs;
        logic          req;
        logic          ovr;
    } obs_t;

    logic          clk;
    logic          reset;
    logic          pixel_clock;
    logic          hsync;
    logic          vsync;
    logic          visible;
    logic [CS-1:0] pixel_x;
    logic [CS-1:0] pixel_y;
    logic          frame_start;
    logic          update_req;
    logic          update_ack;
    logic          overrun;

    obs_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // reference model state
    int   m_r;
    bit   m_pcprev;
    bit   m_pending;
    bit   m_ovr;
    bit   m_hs;
    bit   m_vs;
    bit   m_vis;
    bit   m_fs;

    vga_timing_controller #(
        .HVisible (HV),
        .HFront   (HF),
        .HSyncW   (HSW),
        .HBack    (HB),
        .VVisible (VV),
        .VFront   (VF),
        .VSyncW   (VSW),
        .VBack    (VB),
        .CountSize(CS)
    ) dut (
        .Clock     (clk),
        .Reset     (reset),
        .PixelClock(pixel_clock),
        .HSync     (hsync),
        .VSync     (vsync),
        .Visible   (visible),
        .PixelX    (pixel_x),
        .PixelY    (pixel_y),
        .FrameStart(frame_start),
        .UpdateReq (update_req),
        .UpdateAck (update_ack),
        .Overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pc_mode: 0 toggle, 1 random, 2 held high
    // ack_mode: 0 sparse random, 1 never, 2 exactly on blanking events
    task automatic step(input bit rst_in, input int pc_mode, input int ack_mode);
        bit   pc_v;
        bit   ack_v;
        bit   tick;
        bit   vb;
        int   rn;
        int   x;
        int   y;
        obs_t e;
        @(negedge clk);
        case (pc_mode)
            0:       pc_v = ~pixel_clock;
            1:       pc_v = 1'($urandom_range(0, 1));
            default: pc_v = 1'b1;
        endcase
        tick = !rst_in && pc_v && !m_pcprev;
        rn   = tick ? (m_r + 1) % FT : m_r;
        vb   = tick && (rn == VV * HT);
        case (ack_mode)
            0:       ack_v = ($urandom_range(0, 15) == 0);
            1:       ack_v = 1'b0;
            default: ack_v = vb;
        endcase
        reset       = rst_in;
        pixel_clock = pc_v;
        update_ack  = ack_v;

        if (rst_in) begin
            m_pcprev  = 1'b0;
            m_r       = FT - 1;
            m_pending = 1'b0;
            m_ovr     = 1'b0;
            m_hs      = 1'b1;
            m_vs      = 1'b1;
            m_vis     = 1'b0;
            m_fs      = 1'b0;
        end else begin
            m_pcprev = pc_v;
            m_fs     = 1'b0;
            if (tick) begin
                m_r   = rn;
                x     = m_r % HT;
                y     = m_r / HT;
                m_hs  = !(x >= HV + HF && x < HV + HF + HSW);
                m_vs  = !(y >= VV + VF && y < VV + VF + VSW);
                m_vis = (x < HV) && (y < VV);
                m_fs  = (m_r == 0);
            end
            if (m_pending) begin
                if (vb) begin
                    if (!ack_v) m_ovr = 1'b1;
                end else if (ack_v) begin
                    m_pending = 1'b0;
                end
            end else if (vb) begin
                m_pending = 1'b1;
            end
        end
        e.x   = CS'(m_r % HT);
        e.y   = CS'(m_r / HT);
        e.hs  = m_hs;
        e.vs  = m_vs;
        e.vis = m_vis;
        e.fs  = m_fs;
        e.req = m_pending;
        e.ovr = m_ovr;
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest prediction.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                a.x   = pixel_x;
                a.y   = pixel_y;
                a.hs  = hsync;
                a.vs  = vsync;
                a.vis = visible;
                a.fs  = frame_start;
                a.req = update_req;
                a.ovr = overrun;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL raster t=%0t got x=%0d y=%0d hs=%b vs=%b vis=%b fs=%b req=%b ovr=%b want x=%0d y=%0d hs=%b vs=%b vis=%b fs=%b req=%b ovr=%b",
                             $time, a.x, a.y, a.hs, a.vs, a.vis, a.fs, a.req, a.ovr,
                             e.x, e.y, e.hs, e.vs, e.vis, e.fs, e.req, e.ovr);
                end else begin
                    $display("ok t=%0t x=%0d y=%0d hs=%b vs=%b vis=%b fs=%b req=%b ovr=%b",
                             $time, a.x, a.y, a.hs, a.vs, a.vis, a.fs, a.req, a.ovr);
                end
            end
        end
    end

    // Stimulus phases.
    initial begin
        reset       = 1'b1;
        pixel_clock = 1'b0;
        update_ack  = 1'b0;
        m_r = FT - 1; m_pcprev = 0; m_pending = 0; m_ovr = 0;
        m_hs = 1; m_vs = 1; m_vis = 0; m_fs = 0;

        // reset state, then two full frames at the default one-tick-per-two-cycles rate
        repeat (3) step(1'b1, 0, 1);
        repeat (4 * FT + 20) step(1'b0, 0, 0);

        // ack coincident with blanking events: request stays, no overrun
        step(1'b1, 0, 1);
        repeat (6 * FT + 20) step(1'b0, 0, 2);

        // no ack for over two frames -> overrun, which stays after later acks
        step(1'b1, 0, 1);
        repeat (5 * FT) step(1'b0, 0, 1);
        repeat (2 * FT) step(1'b0, 0, 0);

        // pixel clock held high yields a single tick
        repeat (20) step(1'b0, 2, 0);

        // fully random pixel clock and ack with occasional mid-frame resets
        repeat (12 * FT) step(($urandom_range(0, 399) == 0), 1, 0);

        // reset pulse while a request is outstanding
        step(1'b1, 0, 1);
        repeat (2 * FT + 5 * HT) step(1'b0, 0, 1);
        step(1'b1, 0, 1);
        repeat (10) step(1'b0, 0, 0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
